// File: rtl/qam_bit_packer_if.sv
// Byte-in / symbol-out bus between the frame source, the bit packer and the QAM mapper.
// The packer takes the slave side. The source and mapper, or a bench, take the master side.
interface qam_bit_packer_if #(
    parameter int CNT_W = 16
);
    logic [2:0]       M_ary;
    logic [7:0]       byte_in;
    logic             byte_valid;
    logic             byte_ready;
    logic             flush;
    logic             flush_done;
    logic [15:0]      sym_out;
    logic             sym_valid;
    logic             qam_ready;
    logic [CNT_W-1:0] sym_cnt;

    modport master (
        output M_ary, byte_in, byte_valid, flush, qam_ready,
        input  byte_ready, flush_done, sym_out, sym_valid, sym_cnt
    );

    modport slave (
        input  M_ary, byte_in, byte_valid, flush, qam_ready,
        output byte_ready, flush_done, sym_out, sym_valid, sym_cnt
    );
endinterface

// File: rtl/qam_bit_packer.sv
// Repacks an MSB-first byte stream into k-bit QAM symbols (k = 2/4/6/8/10).
// All outputs are registered copies of next-state decodes, so no input reaches an output combinationally.
module qam_bit_packer #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    qam_bit_packer_if.slave      bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FILL = 3'd1,
        S_EMIT = 3'd2,
        S_PAD  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    function automatic logic [3:0] f_decode(input logic [2:0] m);
        case (m)
            3'b000:  f_decode = 4'd2;
            3'b001:  f_decode = 4'd4;
            3'b010:  f_decode = 4'd6;
            3'b011:  f_decode = 4'd8;
            default: f_decode = 4'd10;
        endcase
    endfunction

    // The oldest unsent k bits sit at [cnt-1 : cnt-k] of the accumulator.
    function automatic logic [15:0] f_emit(input logic [ACC_W-1:0] acc,
                                           input logic [4:0] cnt, input logic [3:0] k);
        f_emit = 16'((acc >> (cnt - {1'b0, k})) & ((ACC_W'(1) << k) - ACC_W'(1)));
    endfunction

    function automatic logic [15:0] f_pad(input logic [ACC_W-1:0] acc,
                                          input logic [4:0] cnt, input logic [3:0] k);
        f_pad = 16'((acc & ((ACC_W'(1) << cnt) - ACC_W'(1))) << ({1'b0, k} - cnt));
    endfunction

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [4:0]         r_bit_cnt;
    logic [3:0]         r_k;
    logic               r_flush_pend;
    logic [CNT_W-1:0]   r_sym_cnt;
    logic               r_byte_ready;
    logic               r_sym_valid;
    logic [15:0]        r_sym_out;
    logic               r_flush_done;

    state_t             w_nxt_state;
    logic [ACC_W-1:0]   w_nxt_acc;
    logic [4:0]         w_nxt_cnt;
    logic [3:0]         w_nxt_k;
    logic               w_nxt_pend;
    logic [15:0]        w_nxt_sym_out;
    logic               w_accept;
    logic               w_xfer;
    logic               w_pend_any;
    logic [4:0]         w_k5;
    logic [4:0]         w_acc_cnt;
    logic [4:0]         w_rem;

    // Next-state, accumulator and bit-count logic.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_acc   = r_acc;
        w_nxt_cnt   = r_bit_cnt;
        w_nxt_k     = r_k;
        w_nxt_pend  = r_flush_pend;
        w_accept    = r_byte_ready && bus.byte_valid;
        w_xfer      = r_sym_valid && bus.qam_ready;
        w_pend_any  = r_flush_pend || bus.flush;
        // In IDLE the symbol size follows M_ary live, so a byte arriving there is packed with the new k.
        w_k5        = (r_state == S_IDLE) ? {1'b0, f_decode(bus.M_ary)} : {1'b0, r_k};
        w_rem       = r_bit_cnt - {1'b0, r_k};
        if (w_accept) begin
            w_nxt_acc = {r_acc[ACC_W-DATA_W-1:0], bus.byte_in};
            w_acc_cnt = r_bit_cnt + 5'd8;
        end else begin
            w_acc_cnt = r_bit_cnt;
        end

        case (r_state)
            S_IDLE: begin
                w_nxt_k = w_k5[3:0];
                if (w_accept) begin
                    w_nxt_cnt   = w_acc_cnt;
                    w_nxt_pend  = w_pend_any;
                    w_nxt_state = (w_acc_cnt >= w_k5) ? S_EMIT : S_FILL;
                end else if (w_pend_any) begin
                    w_nxt_state = S_DONE;
                end else begin
                    w_nxt_state = S_IDLE;
                end
            end
            S_FILL: begin
                w_nxt_pend = w_pend_any;
                if (w_accept) begin
                    w_nxt_cnt   = w_acc_cnt;
                    w_nxt_state = (w_acc_cnt >= w_k5) ? S_EMIT : S_FILL;
                end else if (w_pend_any) begin
                    w_nxt_state = S_PAD;
                end else begin
                    w_nxt_state = S_FILL;
                end
            end
            S_EMIT: begin
                w_nxt_pend = w_pend_any;
                if (w_xfer) begin
                    w_nxt_cnt = w_rem;
                    if (w_rem == 5'd0) begin
                        w_nxt_state = w_pend_any ? S_DONE : S_IDLE;
                    end else if (w_rem < w_k5) begin
                        w_nxt_state = w_pend_any ? S_PAD : S_FILL;
                    end else begin
                        w_nxt_state = S_EMIT;
                    end
                end else begin
                    w_nxt_state = S_EMIT;
                end
            end
            S_PAD: begin
                w_nxt_pend = w_pend_any;
                if (w_xfer) begin
                    w_nxt_cnt   = 5'd0;
                    w_nxt_state = S_DONE;
                end else begin
                    w_nxt_state = S_PAD;
                end
            end
            S_DONE: begin
                w_nxt_pend  = bus.flush;
                w_nxt_state = S_IDLE;
            end
            default: begin
                w_nxt_cnt   = 5'd0;
                w_nxt_pend  = 1'b0;
                w_nxt_state = S_IDLE;
            end
        endcase
    end

    // Symbol word as it will appear once the next state is entered.
    always_comb begin
        case (w_nxt_state)
            S_EMIT:  w_nxt_sym_out = f_emit(w_nxt_acc, w_nxt_cnt, w_nxt_k);
            S_PAD:   w_nxt_sym_out = f_pad(w_nxt_acc, w_nxt_cnt, w_nxt_k);
            default: w_nxt_sym_out = 16'h0000;
        endcase
    end

    // State, datapath and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_acc        <= '0;
            r_bit_cnt    <= 5'd0;
            r_k          <= f_decode(bus.M_ary);
            r_flush_pend <= 1'b0;
            r_sym_cnt    <= '0;
            r_byte_ready <= 1'b1;
            r_sym_valid  <= 1'b0;
            r_sym_out    <= 16'h0000;
            r_flush_done <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_acc        <= w_nxt_acc;
            r_bit_cnt    <= w_nxt_cnt;
            r_k          <= w_nxt_k;
            r_flush_pend <= w_nxt_pend;
            r_sym_cnt    <= r_sym_cnt + {{(CNT_W-1){1'b0}}, w_xfer};
            r_byte_ready <= (w_nxt_state == S_IDLE) || (w_nxt_state == S_FILL);
            r_sym_valid  <= (w_nxt_state == S_EMIT) || (w_nxt_state == S_PAD);
            r_sym_out    <= w_nxt_sym_out;
            r_flush_done <= (w_nxt_state == S_DONE);
        end
    end

    assign bus.byte_ready = r_byte_ready;
    assign bus.sym_valid  = r_sym_valid;
    assign bus.sym_out    = r_sym_out;
    assign bus.flush_done = r_flush_done;
    assign bus.sym_cnt    = r_sym_cnt;

endmodule

// File: tb/tb_qam_bit_packer.sv
// Directed bench for qam_bit_packer: inputs change 1 ns after a rising edge, outputs are sampled there too.
module tb_qam_bit_packer;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    qam_bit_packer_if #(.CNT_W(16)) bus ();

    qam_bit_packer #(.DATA_W(8), .ACC_W(24), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.M_ary = 3'b001;
        bus.byte_in = 8'h00;
        bus.byte_valid = 1'b0;
        bus.flush = 1'b0;
        bus.qam_ready = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        checks++; if (bus.byte_ready !== 1'b1) begin errors++; $display("FAIL reset_byte_ready: got %b expected 1", bus.byte_ready); end
        checks++; if (bus.sym_valid !== 1'b0) begin errors++; $display("FAIL reset_sym_valid: got %b expected 0", bus.sym_valid); end
        checks++; if (bus.sym_out !== 16'h0000) begin errors++; $display("FAIL reset_sym_out: got %h expected 0000", bus.sym_out); end
        checks++; if (bus.flush_done !== 1'b0) begin errors++; $display("FAIL reset_flush_done: got %b expected 0", bus.flush_done); end
        checks++; if (bus.sym_cnt !== 16'd0) begin errors++; $display("FAIL reset_sym_cnt: got %0d expected 0", bus.sym_cnt); end
        tick();
    endtask

    task automatic test_k4();
        bus.M_ary = 3'b001;
        bus.byte_in = 8'hA5;
        bus.byte_valid = 1'b1;
        tick();
        bus.byte_valid = 1'b0;
        checks++; if (bus.sym_valid !== 1'b1 || bus.sym_out !== 16'h000A) begin errors++; $display("FAIL k4_sym0: got v=%b %h expected v=1 000a", bus.sym_valid, bus.sym_out); end
        checks++; if (bus.byte_ready !== 1'b0) begin errors++; $display("FAIL k4_ready_low: got %b expected 0", bus.byte_ready); end
        tick();
        checks++; if (bus.sym_valid !== 1'b1 || bus.sym_out !== 16'h0005) begin errors++; $display("FAIL k4_sym1: got v=%b %h expected v=1 0005", bus.sym_valid, bus.sym_out); end
        tick();
        checks++; if (bus.sym_valid !== 1'b0 || bus.byte_ready !== 1'b1) begin errors++; $display("FAIL k4_idle: got v=%b r=%b expected v=0 r=1", bus.sym_valid, bus.byte_ready); end
        checks++; if (bus.sym_cnt !== 16'd2) begin errors++; $display("FAIL k4_sym_cnt: got %0d expected 2", bus.sym_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_sym [4];
        exp_sym = '{16'h0002, 16'h0003, 16'h0001, 16'h0000};
        bus.M_ary = 3'b000;
        bus.byte_in = 8'hB4;
        bus.byte_valid = 1'b1;
        tick();
        bus.byte_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.sym_valid !== 1'b1 || bus.sym_out !== exp_sym[i] || bus.byte_ready !== 1'b0) begin
                errors++;
                $display("FAIL k2_sym%0d: got v=%b r=%b %h expected v=1 r=0 %h", i, bus.sym_valid, bus.byte_ready, bus.sym_out, exp_sym[i]);
            end
            tick();
        end
        checks++; if (bus.byte_ready !== 1'b1 || bus.sym_valid !== 1'b0) begin errors++; $display("FAIL k2_ready_back: got r=%b v=%b expected r=1 v=0", bus.byte_ready, bus.sym_valid); end
        checks++; if (bus.sym_cnt !== 16'd6) begin errors++; $display("FAIL k2_sym_cnt: got %0d expected 6", bus.sym_cnt); end
    endtask

    task automatic test_k6_stream();
        logic [7:0]  bytes [3];
        logic [15:0] exp_sym [4];
        logic [15:0] got [4];
        int          idx;
        int          n;
        logic        accepted;
        bytes   = '{8'hFC, 8'h0F, 8'hC0};
        exp_sym = '{16'h003F, 16'h0000, 16'h003F, 16'h0000};
        idx = 0;
        n = 0;
        bus.M_ary = 3'b010;
        bus.byte_in = bytes[0];
        bus.byte_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            accepted = bus.byte_ready && bus.byte_valid;
            tick();
            if (accepted) begin
                idx++;
                if (idx < 3) bus.byte_in = bytes[idx];
                else bus.byte_valid = 1'b0;
            end
            if (bus.sym_valid && n < 4) begin
                got[n] = bus.sym_out;
                n++;
            end
            if (n == 4 && bus.byte_ready && !bus.sym_valid) break;
        end
        bus.byte_valid = 1'b0;
        checks++; if (n !== 4) begin errors++; $display("FAIL k6_count: got %0d symbols expected 4", n); end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (got[i] !== exp_sym[i]) begin errors++; $display("FAIL k6_sym%0d: got %h expected %h", i, got[i], exp_sym[i]); end
        end
        checks++; if (bus.byte_ready !== 1'b1 || bus.sym_valid !== 1'b0) begin errors++; $display("FAIL k6_idle: got r=%b v=%b expected r=1 v=0", bus.byte_ready, bus.sym_valid); end
        checks++; if (bus.sym_cnt !== 16'd10) begin errors++; $display("FAIL k6_sym_cnt: got %0d expected 10", bus.sym_cnt); end
    endtask

    task automatic test_flush_pad();
        bus.M_ary = 3'b100;
        bus.byte_in = 8'hFF;
        bus.byte_valid = 1'b1;
        tick();
        bus.byte_valid = 1'b0;
        checks++; if (bus.byte_ready !== 1'b1 || bus.sym_valid !== 1'b0) begin errors++; $display("FAIL k10_fill: got r=%b v=%b expected r=1 v=0", bus.byte_ready, bus.sym_valid); end
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        checks++; if (bus.sym_valid !== 1'b1 || bus.sym_out !== 16'h03FC) begin errors++; $display("FAIL pad_sym: got v=%b %h expected v=1 03fc", bus.sym_valid, bus.sym_out); end
        checks++; if (bus.flush_done !== 1'b0) begin errors++; $display("FAIL pad_done_early: got %b expected 0", bus.flush_done); end
        tick();
        checks++; if (bus.flush_done !== 1'b1 || bus.sym_valid !== 1'b0) begin errors++; $display("FAIL flush_done: got d=%b v=%b expected d=1 v=0", bus.flush_done, bus.sym_valid); end
        tick();
        checks++; if (bus.flush_done !== 1'b0 || bus.byte_ready !== 1'b1) begin errors++; $display("FAIL flush_done_pulse: got d=%b r=%b expected d=0 r=1", bus.flush_done, bus.byte_ready); end
        checks++; if (bus.sym_cnt !== 16'd11) begin errors++; $display("FAIL pad_sym_cnt: got %0d expected 11", bus.sym_cnt); end
    endtask

    task automatic test_stall();
        bus.M_ary = 3'b011;
        bus.qam_ready = 1'b0;
        bus.byte_in = 8'hA3;
        bus.byte_valid = 1'b1;
        tick();
        bus.byte_in = 8'h5C;
        bus.M_ary = 3'b000;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.sym_valid !== 1'b1 || bus.sym_out !== 16'h00A3 || bus.byte_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: got v=%b r=%b %h expected v=1 r=0 00a3", i, bus.sym_valid, bus.byte_ready, bus.sym_out);
            end
            tick();
        end
        bus.byte_valid = 1'b0;
        bus.qam_ready = 1'b1;
        tick();
        checks++; if (bus.sym_valid !== 1'b0 || bus.byte_ready !== 1'b1) begin errors++; $display("FAIL stall_idle: got v=%b r=%b expected v=0 r=1", bus.sym_valid, bus.byte_ready); end
        checks++; if (bus.sym_cnt !== 16'd12) begin errors++; $display("FAIL stall_sym_cnt: got %0d expected 12", bus.sym_cnt); end
        bus.byte_in = 8'hC6;
        bus.byte_valid = 1'b1;
        tick();
        bus.byte_valid = 1'b0;
        checks++; if (bus.sym_valid !== 1'b1 || bus.sym_out !== 16'h0003) begin errors++; $display("FAIL new_k_sym0: got v=%b %h expected v=1 0003", bus.sym_valid, bus.sym_out); end
        tick();
        tick();
        tick();
        checks++; if (bus.sym_out !== 16'h0002) begin errors++; $display("FAIL new_k_sym3: got %h expected 0002", bus.sym_out); end
        tick();
        checks++; if (bus.sym_cnt !== 16'd16 || bus.sym_valid !== 1'b0) begin errors++; $display("FAIL new_k_drain: got cnt=%0d v=%b expected cnt=16 v=0", bus.sym_cnt, bus.sym_valid); end
    endtask

    task automatic test_reset_mid_emit();
        bus.M_ary = 3'b000;
        bus.qam_ready = 1'b1;
        bus.byte_in = 8'hFF;
        bus.byte_valid = 1'b1;
        tick();
        bus.byte_valid = 1'b0;
        tick();
        bus.qam_ready = 1'b0;
        checks++; if (bus.sym_valid !== 1'b1 || bus.sym_out !== 16'h0003) begin errors++; $display("FAIL mid_emit: got v=%b %h expected v=1 0003", bus.sym_valid, bus.sym_out); end
        rst = 1'b0;
        bus.M_ary = 3'b001;
        tick();
        rst = 1'b1;
        checks++; if (bus.sym_valid !== 1'b0 || bus.byte_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_out: got v=%b r=%b expected v=0 r=1", bus.sym_valid, bus.byte_ready); end
        checks++; if (bus.sym_cnt !== 16'd0 || bus.sym_out !== 16'h0000) begin errors++; $display("FAIL rst_mid_cnt: got cnt=%0d sym=%h expected 0 0000", bus.sym_cnt, bus.sym_out); end
        bus.qam_ready = 1'b1;
        bus.byte_in = 8'h5A;
        bus.byte_valid = 1'b1;
        tick();
        bus.byte_valid = 1'b0;
        checks++; if (bus.sym_valid !== 1'b1 || bus.sym_out !== 16'h0005) begin errors++; $display("FAIL rst_mid_k4: got v=%b %h expected v=1 0005", bus.sym_valid, bus.sym_out); end
        tick();
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_k4();
        test_back_to_back();
        test_k6_stream();
        test_flush_pad();
        test_stall();
        test_reset_mid_emit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
